// File: rtl/sub_seq_pkg.sv
// sub_seq_pkg: shared state encoding and nibble constants for the serial subtractor controller
package sub_seq_pkg;

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    localparam int NIBBLE_W    = 4;
    localparam int MAX_NIBBLES = 4;

endpackage

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: nibble-serial A-B through an external 4-bit subtractor; SUB_SIGNMAG_EN adds a sign/magnitude pass
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          req,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   result,
    output logic                          neg,
    output logic [NIBBLE_W-1:0]           sub_x,
    output logic [NIBBLE_W-1:0]           sub_y,
    output logic                          sub_bin,
    input  logic [NIBBLE_W-1:0]           sub_diff,
    input  logic                          sub_bout
);

    localparam logic [1:0] K_LAST = 2'(NIBBLES - 1);

    typedef logic [NIBBLE_W-1:0] nib_t;

    state_t state;
    logic [1:0] k;
    logic brw;
    logic sign;
    nib_t a   [MAX_NIBBLES];
    nib_t b   [MAX_NIBBLES];
    nib_t acc [MAX_NIBBLES];
    logic [NIBBLE_W*NIBBLES-1:0] acc_flat;

    // reassemble the nibble accumulator into the result word
    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < NIBBLES; i++)
            acc_flat[i*NIBBLE_W +: NIBBLE_W] = acc[i];
    end

    // subtractor operands: minuend/subtrahend in SUB, 0-acc in NEG, idle zeros otherwise
    always_comb begin
        sub_x   = (state == SUB) ? a[k] : '0;
        sub_y   = (state == SUB) ? b[k] : (state == NEG) ? acc[k] : '0;
        sub_bin = (state == SUB || state == NEG) && brw;
    end

    // sequencer: one nibble per clock, borrow carried in brw, outputs registered
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            k      <= '0;
            brw    <= 1'b0;
            sign   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            neg    <= 1'b0;
            a      <= '{default: '0};
            b      <= '{default: '0};
            acc    <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        a[i] <= op_a[i*NIBBLE_W +: NIBBLE_W];
                        b[i] <= op_b[i*NIBBLE_W +: NIBBLE_W];
                    end
                    k     <= '0;
                    brw   <= 1'b0;
                    sign  <= 1'b0;
                    busy  <= 1'b1;
                    state <= SUB;
                end
                SUB: begin
                    acc[k] <= sub_diff;
                    brw    <= sub_bout;
                    k      <= k + 2'd1;
                    if (k == K_LAST) begin
                        sign <= sub_bout;
                        k    <= '0;
                        brw  <= 1'b0;
`ifdef SUB_SIGNMAG_EN
                        busy  <= sub_bout;
                        state <= sub_bout ? NEG : DONE;
`else
                        busy  <= 1'b0;
                        state <= DONE;
`endif
                    end
                end
`ifdef SUB_SIGNMAG_EN
                NEG: begin
                    acc[k] <= sub_diff;
                    brw    <= sub_bout;
                    k      <= k + 2'd1;
                    if (k == K_LAST) begin
                        k     <= '0;
                        brw   <= 1'b0;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    result <= acc_flat;
                    neg    <= sign;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb_sub_seq_ctrl: scoreboard bench for sub_seq_ctrl with a behavioural subtractor; honours SUB_SIGNMAG_EN
module tb_sub_seq_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       busy, done, neg, sub_bin, sub_bout;
    logic [7:0] result;
    logic [3:0] sub_x, sub_y, sub_diff;

    logic       req1 = 1'b0;
    logic [3:0] op_a1 = '0;
    logic [3:0] op_b1 = '0;
    logic       busy1, done1, neg1, sub_bin1, sub_bout1;
    logic [3:0] result1, sub_x1, sub_y1, sub_diff1;

    always #5 clk = ~clk;

    assign {sub_bout, sub_diff}   = 5'({1'b0, sub_x}) - 5'({1'b0, sub_y}) - 5'(sub_bin);
    assign {sub_bout1, sub_diff1} = 5'({1'b0, sub_x1}) - 5'({1'b0, sub_y1}) - 5'(sub_bin1);

    sub_seq_ctrl #(.NIBBLES(N)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .neg(neg),
        .sub_x(sub_x), .sub_y(sub_y), .sub_bin(sub_bin),
        .sub_diff(sub_diff), .sub_bout(sub_bout)
    );

    sub_seq_ctrl #(.NIBBLES(1)) dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .req(req1), .op_a(op_a1), .op_b(op_b1),
        .busy(busy1), .done(done1), .result(result1), .neg(neg1),
        .sub_x(sub_x1), .sub_y(sub_y1), .sub_bin(sub_bin1),
        .sub_diff(sub_diff1), .sub_bout(sub_bout1)
    );

    typedef struct {
        logic [7:0] res;
        logic       ng;
        int         lat;
        int         bsy;
        int         due;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference: unsigned A-B mod 256, optionally folded to sign/magnitude
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int at);
        exp_t e;
        e.ng = a < b;
`ifdef SUB_SIGNMAG_EN
        e.res = e.ng ? 8'(b - a) : 8'(a - b);
        e.lat = e.ng ? 2 * N + 1 : N + 1;
`else
        e.res = 8'(a - b);
        e.lat = N + 1;
`endif
        e.bsy = e.lat - 1;
        e.due = at + e.lat;
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) busy_cnt = 0;
        else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done=1 at cycle %0d, expected no done", cyc);
                end else begin
                    e = q.pop_front();
                    check("result", int'(result), int'(e.res));
                    check("neg", int'(neg), int'(e.ng));
                    check("done_cycle", cyc, e.due);
                    check("busy_cycles", busy_cnt, e.bsy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic start(input logic [7:0] a, input logic [7:0] b, input bit hold, output exp_t e);
        @(negedge clk);
        op_a = a;
        op_b = b;
        req = 1'b1;
        @(posedge clk);
        #1;
        e = model(a, b, cyc);
        q.push_back(e);
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        start(a, b, 1'b0, e);
        drain();
    endtask

    initial begin
        exp_t e, e2;
        int c0, got;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_neg", int'(neg), 0);
        check("rst_sub_x", int'(sub_x), 0);
        check("rst_sub_y", int'(sub_y), 0);
        check("rst_sub_bin", int'(sub_bin), 0);
        @(negedge clk);
        rst_n = 1'b1;

        op(8'h53, 8'h21);
        op(8'h21, 8'h53);
        op(8'h5A, 8'h5A);

        start(8'h10, 8'h01, 1'b0, e);
        @(negedge clk);
        check("chain_lo_x", int'(sub_x), 0);
        check("chain_lo_y", int'(sub_y), 1);
        check("chain_lo_bin", int'(sub_bin), 0);
        @(negedge clk);
        check("chain_hi_x", int'(sub_x), 1);
        check("chain_hi_y", int'(sub_y), 0);
        check("chain_hi_bin", int'(sub_bin), 1);
        drain();

        start(8'h44, 8'h12, 1'b0, e);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        start(8'h12, 8'h99, 1'b0, e);
        do @(negedge clk); while (cyc < e.due - 1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        start(8'hC7, 8'h35, 1'b1, e);
        repeat (e.lat + 1) @(posedge clk);
        #1;
        e2 = model(8'hC7, 8'h35, cyc);
        q.push_back(e2);
        req = 1'b0;
        drain();

        start(8'h80, 8'h7F, 1'b0, e);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        check("abort_neg", int'(neg), 0);
        check("abort_sub_x", int'(sub_x), 0);
        check("abort_sub_y", int'(sub_y), 0);
        check("abort_sub_bin", int'(sub_bin), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        op(8'h80, 8'h7F);

        for (int i = 0; i < 40; i++) begin
            start(8'($urandom), 8'($urandom), 1'b0, e);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req = 1'b1;
                @(negedge clk);
                req = 1'b0;
            end
            drain();
        end

        @(negedge clk);
        op_a1 = 4'h3;
        op_b1 = 4'h5;
        req1 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        req1 = 1'b0;
        got = -1;
        for (int i = 0; i < 10 && got < 0; i++) begin
            @(negedge clk);
            if (done1) got = cyc - c0;
        end
`ifdef SUB_SIGNMAG_EN
        check("n1_latency", got, 3);
        check("n1_result", int'(result1), 2);
`else
        check("n1_latency", got, 2);
        check("n1_result", int'(result1), 14);
`endif
        check("n1_neg", int'(neg1), 1);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sub_seq_ctrl.md
# sub_seq_ctrl

Sequencing controller for the shared 4-bit ripple-borrow subtractor on the DE2-70 arithmetic display path. It performs a multi-nibble subtraction A−B serially, one nibble per clock, by driving the external subtractor's operand and borrow-in ports and capturing its difference and borrow-out. An optional pass turns a negative result into sign and magnitude so the downstream BCD converter and 7-segment path can display it. Requesters use a single req/done handshake.

## Interface
Parameters:
- NIBBLES, 2, operand width in nibbles; legal range 1..4; W = 4*NIBBLES.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE.
- op_a  in  W  minuend; latched on accept.
- op_b  in  W  subtrahend; latched on accept.
- busy  out  1  high in SUB and NEG states.
- done  out  1  one-cycle pulse in DONE state.
- result  out  W  registered difference or magnitude; holds until the next DONE.
- neg  out  1  registered flag set when A<B (unsigned); holds with result.
- sub_x  out  4  minuend nibble to the subtractor.
- sub_y  out  4  subtrahend nibble to the subtractor.
- sub_bin  out  1  borrow-in to the subtractor.
- sub_diff  in  4  subtractor difference (combinational from sub_x, sub_y, sub_bin).
- sub_bout  in  1  subtractor borrow-out.

## Operation
- States: IDLE, SUB, NEG, DONE. Nibble index k counts 0..NIBBLES-1.
- IDLE with req=1 is the accept condition:
  - latch op_a and op_b; clear k and the borrow register; go to SUB.
- SUB:
  - drive sub_x=A[k], sub_y=B[k], sub_bin=brw (0 at k=0).
  - capture sub_diff into acc[k] and sub_bout into brw.
  - at k=NIBBLES-1, the final sub_bout sets the internal sign.
  - next state is NEG if the sign is set and SUB_SIGNMAG_EN is defined; otherwise DONE.
- NEG (two's-complement negate of acc):
  - drive sub_x=0, sub_y=acc[k], sub_bin=brw (0 at k=0).
  - write sub_diff back to acc[k].
  - after nibble NIBBLES-1, go to DONE.
- DONE:
  - result←acc and neg←sign on entry.
  - done=1 for exactly one cycle.
  - next state is IDLE.
- When not busy, sub_x, sub_y and sub_bin are driven to 0.
- req is ignored in SUB, NEG and DONE; no queuing. A request held high through DONE is accepted on the following IDLE cycle.
- Arithmetic is modulo 2^W. The A=B case gives result 0 and neg=0.
- Reset values: state IDLE; busy, done, neg, sub_x, sub_y and sub_bin all 0; result 0; internal registers 0.
- Reset asserted mid-operation aborts immediately. result and neg are cleared, not held.

## Timing
- Accept occurs at edge 0. busy rises after edge 0.
- Positive result, or macro undefined: done is high in the cycle after edge NIBBLES+1, which is 3 cycles after accept for NIBBLES=2. result is valid the same cycle.
- Negative result with the macro defined: done follows edge 2*NIBBLES+1, which is 5 cycles after accept for NIBBLES=2.
- Minimum spacing between accepts is latency+1 cycles, because DONE returns to IDLE.
- The subtractor path is a single-cycle combinational path from sub_x/sub_y/sub_bin to sub_diff/sub_bout.

## Configuration
- SUB_SIGNMAG_EN:
  - Defined: a negative result is negated through the NEG state, so result is the magnitude and neg=1.
  - Undefined: the NEG state is not compiled, result is raw two's complement, and neg is the final borrow.

## Structure
- Shared package sub_seq_pkg holds:
  - the state enum (IDLE, SUB, NEG, DONE);
  - the constant NIBBLE_W=4;
  - the constant MAX_NIBBLES=4.
- No sub-module. The nibble select and write-back are inline. The 4-bit subtractor is instantiated by the parent and connected through the sub_* ports.

## Test plan
- NIBBLES=2, A=0x53, B=0x21 → result=0x32, neg=0; done 3 cycles after accept; busy high for exactly 2 cycles.
- A=0x21, B=0x53:
  - macro undefined → result=0xCE, neg=1, done at +3;
  - macro defined → result=0x32, neg=1, done at +5.
- Borrow chain: A=0x10, B=0x01 → result=0x0F, neg=0. The trace shows sub_bin=1 on the high nibble.
- req pulsed again during SUB and during DONE → not accepted; result from the first operation holds. A req held through DONE starts a new operation from IDLE.
- RESET_N pulsed low during SUB of A=0x80, B=0x7F → all outputs 0 immediately; no done pulse; the next request completes normally.
- NIBBLES=1, A=0x3, B=0x5 → macro defined: result=0x2, neg=1, done at +3.
